// File: rtl/apo_packet_injector.sv
// rtl/apo_packet_injector.sv - circulant-NoC injection stage: request FIFO, link-idle gated in_free injection, counters.
// Optional starvation monitor enabled by defining STARVE_GUARD_EN.
module apo_packet_injector #(
  parameter int K            = 7,
  parameter int N2           = 15,
  parameter int NODE_COUNT   = 100,
  parameter int FIFO_DEPTH   = 4,
  parameter int GAP          = 0,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [K-1:0]                  router_name,
  input  logic                          req_valid,
  input  logic [K-1:0]                  req_dest,
  output logic                          req_ready,
  input  logic [N2-1:0]                 link_r1R,
  input  logic [N2-1:0]                 link_r2R,
  input  logic [N2-1:0]                 link_r1L,
  input  logic [N2-1:0]                 link_r2L,
  input  logic                          delivered,
  output logic [N2-1:0]                 out_free,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   inj_count,
  output logic [15:0]                   dlv_count,
  output logic [15:0]                   drop_count,
  output logic                          starve_flag
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [K:0] NODE_LIM = (K+1)'(NODE_COUNT);

  typedef enum logic [0:0] {S_IDLE, S_GAP} state_t;

  state_t          state;
  logic [GW-1:0]   gap_cnt;
  logic [K-1:0]    mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic            full;
  logic            empty;
  logic            busy;
  logic            accept;
  logic            push;
  logic            inject;
  logic [K-1:0]    head;

  // router_name and the payload bits of the taps are observation-only here
  logic unused_bits;
  assign unused_bits = ^{router_name, link_r1R[N2-2:0], link_r2R[N2-2:0],
                         link_r1L[N2-2:0], link_r2L[N2-2:0]};

  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty      = (wr_ptr == rd_ptr);
  assign fifo_level = wr_ptr - rd_ptr;
  assign req_ready  = !full;
  assign accept     = req_valid && req_ready;
  assign push       = accept && ({1'b0, req_dest} < NODE_LIM);
  assign head       = mem[rd_ptr[AW-1:0]];

  // in_free outranks transit traffic in the router, so any live neighbour input blocks us
  assign busy   = link_r1R[N2-1] | link_r2R[N2-1] | link_r1L[N2-1] | link_r2L[N2-1];
  assign inject = (state == S_IDLE) && !empty && !busy;

  always_comb begin
    out_free = '0;
    if (inject) out_free = {1'b1, {(N2-1-K){1'b0}}, head};
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= req_dest;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (inject) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      gap_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (inject && (GAP > 0)) begin
            state   <= S_GAP;
            gap_cnt <= GW'(GAP - 1);
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) state <= S_IDLE;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inj_count  <= '0;
      dlv_count  <= '0;
      drop_count <= '0;
    end else begin
      if (inject && inj_count != 16'hFFFF)             inj_count  <= inj_count + 1'b1;
      if (delivered && dlv_count != 16'hFFFF)          dlv_count  <= dlv_count + 1'b1;
      if (accept && !push && drop_count != 16'hFFFF)   drop_count <= drop_count + 1'b1;
    end
  end

`ifdef STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;

  // counts consecutive blocked cycles with work pending; the flag is sticky until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt  <= '0;
      starve_flag <= 1'b0;
    end else if (inject) begin
      starve_cnt <= '0;
    end else if ((state == S_IDLE) && !empty && busy) begin
      if (starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
      if (starve_cnt == SW'(STARVE_LIMIT - 1)) starve_flag <= 1'b1;
    end
  end
`else
  assign starve_flag = 1'b0;
`endif

endmodule

// File: tb/tb_apo_packet_injector.sv
// tb/tb_apo_packet_injector.sv - directed scoreboard bench for apo_packet_injector (GAP=0 and GAP=2 instances).
module tb_apo_packet_injector;

  logic        clk;
  logic        rst;
  logic [6:0]  router_name;
  logic        req_valid, req_valid_g;
  logic [6:0]  req_dest, req_dest_g;
  logic        req_ready, req_ready_g;
  logic [14:0] link_r1R, link_r2R, link_r1L, link_r2L;
  logic [14:0] idle_link;
  logic        delivered;
  logic [14:0] out_free, out_free_g;
  logic [2:0]  fifo_level, fifo_level_g;
  logic [15:0] inj_count, dlv_count, drop_count;
  logic [15:0] inj_count_g, dlv_count_g, drop_count_g;
  logic        starve_flag, starve_flag_g;

  int checks = 0;
  int errors = 0;
  logic [14:0] sbq[$];

  apo_packet_injector dut (
    .clk(clk), .rst(rst), .router_name(router_name),
    .req_valid(req_valid), .req_dest(req_dest), .req_ready(req_ready),
    .link_r1R(link_r1R), .link_r2R(link_r2R), .link_r1L(link_r1L), .link_r2L(link_r2L),
    .delivered(delivered), .out_free(out_free), .fifo_level(fifo_level),
    .inj_count(inj_count), .dlv_count(dlv_count), .drop_count(drop_count),
    .starve_flag(starve_flag)
  );

  apo_packet_injector #(.GAP(2)) dut_g (
    .clk(clk), .rst(rst), .router_name(router_name),
    .req_valid(req_valid_g), .req_dest(req_dest_g), .req_ready(req_ready_g),
    .link_r1R(idle_link), .link_r2R(idle_link), .link_r1L(idle_link), .link_r2L(idle_link),
    .delivered(1'b0), .out_free(out_free_g), .fifo_level(fifo_level_g),
    .inj_count(inj_count_g), .dlv_count(dlv_count_g), .drop_count(drop_count_g),
    .starve_flag(starve_flag_g)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // every non-zero out_free must match the oldest outstanding expected packet
  always @(negedge clk) begin
    if (!rst && out_free !== 15'd0) begin
      if (sbq.size() == 0) chk("unexpected_inject", {17'd0, out_free}, 32'd0);
      else                 chk("sb_inject", {17'd0, out_free}, {17'd0, sbq.pop_front()});
    end
  end

  initial begin
    logic [14:0] e;
    int t0, t1, n;
    logic [14:0] v0, v1;
    rst = 1'b1; router_name = 7'd0; req_valid = 1'b0; req_dest = '0;
    req_valid_g = 1'b0; req_dest_g = '0; delivered = 1'b0; idle_link = '0;
    link_r1R = '0; link_r2R = '0; link_r1L = '0; link_r2L = '0;
    tick; tick;
    rst = 1'b0;
    chk("rst_out_free", {17'd0, out_free}, 32'd0);
    chk("rst_level", {29'd0, fifo_level}, 32'd0);
    chk("rst_inj", {16'd0, inj_count}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_starve", {31'd0, starve_flag}, 32'd0);

    // 1: single request, one-cycle latency, one-cycle pulse
    req_valid = 1'b1; req_dest = 7'd15; sbq.push_back(15'h400F);
    tick;
    req_valid = 1'b0;
    chk("t1_out_free", {17'd0, out_free}, 32'h400F);
    chk("t1_level", {29'd0, fifo_level}, 32'd1);
    tick;
    chk("t1_out_free_after", {17'd0, out_free}, 32'd0);
    chk("t1_inj", {16'd0, inj_count}, 32'd1);

    // 2: transit packet blocks injection
    link_r1R = 15'h4001;
    req_valid = 1'b1; req_dest = 7'd20; sbq.push_back(15'h4014);
    tick;
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_blocked", {17'd0, out_free}, 32'd0);
      tick;
    end
    link_r1R = 15'h3FFF;
    #1;
    chk("t2_release", {17'd0, out_free}, 32'h4014);
    tick;
    chk("t2_after", {17'd0, out_free}, 32'd0);
    chk("t2_inj", {16'd0, inj_count}, 32'd2);
    link_r1R = '0;

    // 3: out-of-range destination
    req_valid = 1'b1; req_dest = 7'd100;
    tick;
    req_valid = 1'b0;
    chk("t3_drop", {16'd0, drop_count}, 32'd1);
    chk("t3_level", {29'd0, fifo_level}, 32'd0);
    chk("t3_ready", {31'd0, req_ready}, 32'd1);
    tick; tick;

    // 4: fill while blocked, then back-to-back drain
    link_r2L = 15'h4003;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_dest = 7'(30 + i);
      sbq.push_back(15'h4000 | 15'(30 + i));
      tick;
    end
    chk("t4_level_full", {29'd0, fifo_level}, 32'd4);
    chk("t4_ready_full", {31'd0, req_ready}, 32'd0);
    req_dest = 7'd34;
    tick;
    req_valid = 1'b0;
    chk("t4_level_5th", {29'd0, fifo_level}, 32'd4);
    chk("t4_drop_5th", {16'd0, drop_count}, 32'd1);
    link_r2L = '0;
    #1;
    for (int i = 0; i < 4; i++) begin
      e = 15'h4000 | 15'(30 + i);
      chk("t4_drain", {17'd0, out_free}, {17'd0, e});
      tick;
    end
    chk("t4_drain_done", {17'd0, out_free}, 32'd0);
    chk("t4_level_empty", {29'd0, fifo_level}, 32'd0);
    chk("t4_inj", {16'd0, inj_count}, 32'd6);

    // 5: GAP=2 instance spaces injections three cycles apart; delivered counting
    req_valid_g = 1'b1; req_dest_g = 7'd50;
    tick;
    req_dest_g = 7'd51;
    t0 = -1; t1 = -1; n = 0; v0 = '0; v1 = '0;
    for (int t = 0; t < 12; t++) begin
      if (out_free_g !== 15'd0) begin
        if (n == 0) begin t0 = t; v0 = out_free_g; end
        else if (n == 1) begin t1 = t; v1 = out_free_g; end
        n++;
      end
      tick;
      if (t == 0) req_valid_g = 1'b0;
    end
    chk("t5_n_inj", n, 32'd2);
    chk("t5_v0", {17'd0, v0}, 32'h4032);
    chk("t5_v1", {17'd0, v1}, 32'h4033);
    chk("t5_spacing", t1 - t0, 32'd3);
    chk("t5_inj_g", {16'd0, inj_count_g}, 32'd2);
    delivered = 1'b1; tick;
    delivered = 1'b0; tick;
    delivered = 1'b1; tick;
    delivered = 1'b0; tick;
    chk("t5_dlv", {16'd0, dlv_count}, 32'd2);

    // 6: asynchronous reset with queued requests
    link_r2L = 15'h4003;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_dest = 7'(60 + i);
      tick;
    end
    req_valid = 1'b0;
    chk("t6_level_pre", {29'd0, fifo_level}, 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_out_free", {17'd0, out_free}, 32'd0);
    chk("t6_rst_level", {29'd0, fifo_level}, 32'd0);
    chk("t6_rst_inj", {16'd0, inj_count}, 32'd0);
    link_r2L = '0;
    tick; tick;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t6_no_inject", {17'd0, out_free}, 32'd0);
      tick;
    end
    chk("t6_level_post", {29'd0, fifo_level}, 32'd0);
    chk("t6_drop_post", {16'd0, drop_count}, 32'd0);

    // starvation: blocked with work pending for well over the limit
    link_r1L = 15'h4000;
    req_valid = 1'b1; req_dest = 7'd7; sbq.push_back(15'h4007);
    tick;
    req_valid = 1'b0;
    repeat (17) tick;
`ifdef STARVE_GUARD_EN
    chk("t6_starve", {31'd0, starve_flag}, 32'd1);
`else
    chk("t6_starve", {31'd0, starve_flag}, 32'd0);
`endif
    link_r1L = '0;
    #1;
    chk("t6_starve_inject", {17'd0, out_free}, 32'h4007);
    tick;
    chk("t6_inj_post", {16'd0, inj_count}, 32'd1);
`ifdef STARVE_GUARD_EN
    chk("t6_starve_sticky", {31'd0, starve_flag}, 32'd1);
`endif
    tick;
    chk("sb_empty", sbq.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apo_packet_injector.md
Name: apo_packet_injector

Overview:
- Injection stage for one circulant-NoC node. Sits between the IP core and the router's in_free port.
- Queues destination requests from the IP core and injects them as in_free packets, one per slot.
- Injects only in a cycle where no transit packet is present on the router's neighbour inputs. in_free has top input priority in the router, so this gating prevents transit packets from being overwritten.
- Counts injected packets, delivered packets (router out_data) and rejected requests.

Parameters:
- K, 7, width of node numbers.
- N2, 15, packet width; bit N2-1 is the valid marker.
- NODE_COUNT, 100, number of nodes; legal destinations are 0..NODE_COUNT-1.
- FIFO_DEPTH, 4, request queue depth; power of 2, ≥2.
- GAP, 0, minimum idle cycles after each injection.
- STARVE_LIMIT, 16, blocked-cycle threshold (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- router_name  in  K  number of this node (debug/compare only)
- req_valid  in  1  IP core request valid
- req_dest  in  K  requested destination node
- req_ready  out  1  request accepted when high with req_valid
- link_r1R, link_r2R, link_r1L, link_r2L  in  N2 each  monitor taps of the router's neighbour inputs
- delivered  in  1  router out_data
- out_free  out  N2  drives router in_free
- fifo_level  out  log2(FIFO_DEPTH)+1  queue occupancy
- inj_count  out  16  injected packets, saturating
- dlv_count  out  16  delivered packets, saturating
- drop_count  out  16  rejected requests, saturating
- starve_flag  out  1  sticky starvation flag (optional feature)

Behaviour:
- Reset, asynchronous, effective immediately:
  - FIFO flushed; fifo_level=0.
  - out_free=0; all counters=0; starve_flag=0.
  - FSM to IDLE; GAP counter=0.
  - Reset asserted mid-operation discards queued requests. No partial packet is ever emitted.
- req_ready = !full; combinational from registered state only.
- Request accept on a clock edge with req_valid && req_ready:
  - req_dest < NODE_COUNT: pushed to FIFO.
  - req_dest ≥ NODE_COUNT: not stored; drop_count++.
  - Still counts as accepted (handshake completes).
- A push is visible at the FIFO head the following cycle. Minimum request-to-out_free latency is 1 cycle.
- busy = OR of bit N2-1 over the four link_* inputs, in the current cycle.
- FSM states:
  - IDLE: if FIFO non-empty and !busy:
    - out_free = {1'b1, (N2-1-K) zeros, head dest}, combinational in that cycle.
    - At the edge: pop; inj_count++; go to GAP if GAP>0, else stay IDLE.
    - Otherwise out_free=0.
  - GAP: out_free=0; count GAP cycles, then return to IDLE.
  - Back-to-back injection (GAP=0) is one packet per cycle while the FIFO is non-empty and links are idle.
- out_free is non-zero for exactly one cycle per packet. It is 0 in every other cycle.
- Push and pop on the same edge: both occur; level unchanged.
- Full FIFO: req_ready=0 even if a pop occurs that edge.
- dest == router_name: injected normally. The router is expected to assert out_data on the next cycle.
- dlv_count increments on each edge where delivered=1.
- All counters saturate at 16'hFFFF.

Optional Feature:
- Macro STARVE_GUARD_EN.
- Defined:
  - A counter increments each cycle in IDLE with the FIFO non-empty and busy=1. It clears on injection.
  - Reaching STARVE_LIMIT sets starve_flag, which stays set until rst.
  - Injection policy is unchanged; no transit packet is ever overridden.
- Undefined: counter absent; starve_flag tied to 0.

Test Plan:
1. router_name=0, links idle, push req_dest=15 -> next cycle out_free=15'h400F for one cycle, then 0; inj_count=1.
2. link_r1R=15'h4001 held 3 cycles, dest=20 queued -> out_free=0 during those cycles; 15'h4014 emitted in the first cycle all links read <15'h4000.
3. Push req_dest=100 -> drop_count=1, fifo_level stays 0, out_free never asserted.
4. link_r2L=15'h4003 held busy, push 5 requests -> after 4, fifo_level=4 and req_ready=0, 5th not accepted. Release links -> 4 injections on consecutive cycles (GAP=0).
5. GAP=2, two requests queued -> injections exactly 3 cycles apart. Pulse delivered twice -> dlv_count=2.
6. Assert rst with 3 queued -> out_free=0 and fifo_level=0 immediately; no injection after release. With STARVE_GUARD_EN and links busy 16 cycles while queued -> starve_flag=1.
